// File: rtl/pseudo_datapath.sv
// Microcoded datapath stage: accumulator, 4-entry register file, carry flag,
// valid/ready input port and 1-entry output buffer. Optional macro PSEUDO_DP_SATURATE_EN.
module pseudo_datapath #(
    parameter int unsigned P_WIDTH          = 8,
    parameter int unsigned P_NUM_D_CTRLBITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [P_NUM_D_CTRLBITS-1:0] dp_ctrl,
    output logic                        cres,
    input  logic [P_WIDTH-1:0]          in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [P_WIDTH-1:0]          out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [P_WIDTH-1:0]          acc
);

    localparam int unsigned W       = P_WIDTH;
    localparam int unsigned NUM_REG = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ST  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_INP = 3'b101;
    localparam logic [2:0] OP_OUT = 3'b110;
    localparam logic [2:0] OP_TST = 3'b111;

    // The opcode/select split only makes sense for a 5-bit control word.
    generate
        if (P_NUM_D_CTRLBITS != 5) begin : g_ctrl_width_check
            $error("pseudo_datapath: P_NUM_D_CTRLBITS must be 5");
        end
    endgenerate

    logic [2:0]   opcode;
    logic [1:0]   sel;
    logic [W-1:0] rf [NUM_REG];
    logic         carry;
    logic [W-1:0] rs;
    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic         borrow;
    logic [W-1:0] add_res;
    logic [W-1:0] sub_res;
    logic         buf_free;

    logic [W-1:0] acc_d;
    logic         carry_d;
    logic         rf_we;
    logic         out_load;

    assign opcode   = dp_ctrl[4:2];
    assign sel      = dp_ctrl[1:0];
    assign rs       = rf[sel];
    assign sum      = {1'b0, acc} + {1'b0, rs};
    assign diff     = acc - rs;
    assign borrow   = (acc < rs);
    assign buf_free = !out_valid || out_ready;

    // Arithmetic result selection; carry/borrow flag is identical in both builds.
    always_comb begin
        add_res = sum[W-1:0];
        sub_res = diff;
`ifdef PSEUDO_DP_SATURATE_EN
        if (sum[W]) begin
            add_res = '1;
        end
        if (borrow) begin
            sub_res = '0;
        end
`else
        add_res = sum[W-1:0];
        sub_res = diff;
`endif
    end

    // Next-state decode of the control word.
    always_comb begin
        acc_d    = acc;
        carry_d  = carry;
        rf_we    = 1'b0;
        out_load = 1'b0;
        case (opcode)
            OP_LD:  acc_d = rs;
            OP_ST:  rf_we = 1'b1;
            OP_ADD: begin
                acc_d   = add_res;
                carry_d = sum[W];
            end
            OP_SUB: begin
                acc_d   = sub_res;
                carry_d = borrow;
            end
            OP_INP: begin
                if (in_valid) begin
                    acc_d = in_data;
                end
            end
            OP_OUT: out_load = buf_free;
            default: ;
        endcase
    end

    // Same-cycle condition result and input accept; both forced low in reset.
    always_comb begin
        cres     = 1'b0;
        in_ready = 1'b0;
        if (rst) begin
            case (opcode)
                OP_INP: begin
                    in_ready = in_valid;
                    cres     = !in_valid;
                end
                OP_OUT: cres = !buf_free;
                OP_TST: begin
                    case (sel)
                        2'b00:   cres = (acc == '0);
                        2'b01:   cres = carry;
                        2'b10:   cres = acc[W-1];
                        default: cres = 1'b1;
                    endcase
                end
                OP_NOP, OP_LD, OP_ST, OP_ADD, OP_SUB: cres = 1'b0;
                default: cres = 1'b0;
            endcase
        end
    end

    // Architectural state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            carry <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            acc   <= acc_d;
            carry <= carry_d;
            if (rf_we) begin
                rf[sel] <= acc;
            end
        end
    end

    // Output buffer: a load in a draining cycle keeps it full with the new word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_data  <= acc;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pseudo_datapath.sv
// Self-checking bench for pseudo_datapath: directed scenarios then random
// control words, all checked against an integer reference model.
module tb_pseudo_datapath;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] LD  = 3'd1;
    localparam logic [2:0] ST  = 3'd2;
    localparam logic [2:0] ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4;
    localparam logic [2:0] INP = 3'd5;
    localparam logic [2:0] OUT = 3'd6;
    localparam logic [2:0] TST = 3'd7;

    logic         clk;
    logic         rst;
    logic [4:0]   dp_ctrl;
    logic         cres;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] acc;

    pseudo_datapath #(.P_WIDTH(W), .P_NUM_D_CTRLBITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .dp_ctrl   (dp_ctrl),
        .cres      (cres),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state as plain integers.
    int m_a, m_c, m_ov, m_od;
    int m_r [4];
    logic last_cres, last_in_ready;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_c = 0; m_ov = 0; m_od = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
    endtask

    task automatic check_regs();
        check_eq("acc", acc, m_a);
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_data", out_data, m_od);
    endtask

    task automatic do_reset(input int cycles, input logic [4:0] ctrl);
        repeat (cycles) begin
            @(negedge clk);
            rst = 1'b0; dp_ctrl = ctrl; in_valid = 1'b1;
            in_data = W'($urandom); out_ready = 1'($urandom);
            #1;
            check_eq("rst_cres", cres, 0);
            check_eq("rst_in_ready", in_ready, 0);
            @(posedge clk); #1;
            model_reset();
            check_regs();
        end
    endtask

    // One cycle: drive, check combinational outputs, advance model, check registers.
    task automatic step(input logic [2:0] op, input logic [1:0] s, input logic iv,
                        input logic [W-1:0] id, input logic ordy);
        int exp_cres, sum, free;
        @(negedge clk);
        rst = 1'b1; dp_ctrl = {op, s}; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        exp_cres = 0;
        free = (m_ov == 0 || ordy) ? 1 : 0;
        case (op)
            INP: exp_cres = iv ? 0 : 1;
            OUT: exp_cres = free ? 0 : 1;
            TST: case (s)
                2'd0: exp_cres = (m_a == 0) ? 1 : 0;
                2'd1: exp_cres = m_c;
                2'd2: exp_cres = (m_a >> (W - 1)) & 1;
                default: exp_cres = 1;
            endcase
            default: exp_cres = 0;
        endcase
        last_cres = cres;
        last_in_ready = in_ready;
        check_eq("cres", cres, exp_cres);
        check_eq("in_ready", in_ready, (op == INP && iv) ? 1 : 0);

        if (m_ov != 0 && ordy) m_ov = 0;
        case (op)
            LD: m_a = m_r[s];
            ST: m_r[s] = m_a;
            ADD: begin
                sum = m_a + m_r[s];
                m_c = (sum > MASK) ? 1 : 0;
`ifdef PSEUDO_DP_SATURATE_EN
                m_a = (sum > MASK) ? MASK : sum;
`else
                m_a = sum & MASK;
`endif
            end
            SUB: begin
                m_c = (m_a < m_r[s]) ? 1 : 0;
`ifdef PSEUDO_DP_SATURATE_EN
                m_a = (m_a < m_r[s]) ? 0 : m_a - m_r[s];
`else
                m_a = (m_a - m_r[s]) & MASK;
`endif
            end
            INP: if (iv) m_a = int'(id);
            OUT: if (free != 0) begin m_od = m_a; m_ov = 1; end
            default: ;
        endcase
        @(posedge clk); #1;
        check_regs();
    endtask

    initial begin
        rst = 1'b0; dp_ctrl = 5'b111_11; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();

        // 1: reset and idle
        do_reset(2, 5'b111_11);
        step(NOP, 2'd0, 1'b0, 8'h00, 1'b0);
        check_eq("t1_acc", acc, 0);
        check_eq("t1_out_valid", out_valid, 0);
        step(TST, 2'd1, 1'b0, 8'h00, 1'b0);
        check_eq("t1_carry", last_cres, 0);
        step(TST, 2'd3, 1'b0, 8'h00, 1'b0);
        check_eq("t1_tst11", last_cres, 1);

        // 2: load, store, add with carry out
        step(INP, 2'd0, 1'b1, 8'hF0, 1'b0);
        check_eq("t2_inrdy0", last_in_ready, 1);
        step(ST, 2'd2, 1'b0, 8'h00, 1'b0);
        step(INP, 2'd0, 1'b1, 8'h20, 1'b0);
        check_eq("t2_inrdy1", last_in_ready, 1);
        step(ADD, 2'd2, 1'b0, 8'h00, 1'b0);
`ifdef PSEUDO_DP_SATURATE_EN
        check_eq("t2_acc", acc, 8'hFF);
`else
        check_eq("t2_acc", acc, 8'h10);
`endif
        step(TST, 2'd1, 1'b0, 8'h00, 1'b0);
        check_eq("t2_carry", last_cres, 1);

        // 3: subtract with borrow
        step(INP, 2'd0, 1'b1, 8'h05, 1'b0);
        step(ST, 2'd1, 1'b0, 8'h00, 1'b0);
        step(INP, 2'd0, 1'b1, 8'h03, 1'b0);
        step(SUB, 2'd1, 1'b0, 8'h00, 1'b0);
`ifdef PSEUDO_DP_SATURATE_EN
        check_eq("t3_acc", acc, 8'h00);
        step(TST, 2'd0, 1'b0, 8'h00, 1'b0);
        check_eq("t3_zero", last_cres, 1);
`else
        check_eq("t3_acc", acc, 8'hFE);
        step(TST, 2'd2, 1'b0, 8'h00, 1'b0);
        check_eq("t3_sign", last_cres, 1);
`endif
        step(TST, 2'd1, 1'b0, 8'h00, 1'b0);
        check_eq("t3_borrow", last_cres, 1);

        // 4: input stall
        for (int i = 0; i < 3; i++) begin
            step(INP, 2'd0, 1'b0, 8'hC3, 1'b0);
            check_eq("t4_stall_cres", last_cres, 1);
            check_eq("t4_stall_rdy", last_in_ready, 0);
        end
        step(INP, 2'd0, 1'b1, 8'h5A, 1'b0);
        check_eq("t4_go_cres", last_cres, 0);
        check_eq("t4_go_rdy", last_in_ready, 1);
        check_eq("t4_acc", acc, 8'h5A);

        // 5: output back-pressure
        step(NOP, 2'd0, 1'b0, 8'h00, 1'b1);
        step(INP, 2'd0, 1'b1, 8'h11, 1'b0);
        step(OUT, 2'd0, 1'b0, 8'h00, 1'b0);
        check_eq("t5_load_cres", last_cres, 0);
        step(INP, 2'd0, 1'b1, 8'h22, 1'b0);
        step(OUT, 2'd0, 1'b0, 8'h00, 1'b0);
        check_eq("t5_busy_cres", last_cres, 1);
        check_eq("t5_hold_data", out_data, 8'h11);
        step(OUT, 2'd0, 1'b0, 8'h00, 1'b1);
        check_eq("t5_swap_cres", last_cres, 0);
        check_eq("t5_new_data", out_data, 8'h22);
        check_eq("t5_valid", out_valid, 1);

        // 6: reset mid-operation drops the pending word and clears registers
        do_reset(1, {OUT, 2'd0});
        check_eq("t6_out_valid", out_valid, 0);
        check_eq("t6_acc", acc, 0);
        for (int i = 0; i < 4; i++) begin
            step(LD, 2'(i), 1'b0, 8'h00, 1'b0);
            check_eq("t6_reg", acc, 0);
        end

        // Random control words with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(63, 0) == 0) begin
                do_reset(1, 5'($urandom));
            end else begin
                step(3'($urandom), 2'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pseudo_datapath.md
Name: pseudo_datapath

Overview:
- Microcoded datapath stage directly downstream of the microsequencer.
- Consumes the sequencer's per-cycle datapath control word and returns the 1-bit condition result `cres`, which the sequencer uses for conditional jumps in the same cycle.
- Holds an accumulator, a 4-entry register file and a carry flag.
- Provides a valid/ready input port and a 1-entry buffered valid/ready output port. Busy ports are reported through `cres`, so microcode polls them by jumping to itself.

Parameters:
- P_WIDTH, 8, datapath word width in bits (>=2).
- P_NUM_D_CTRLBITS, 5, control word width; fixed at 5, so any other value is a design error.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-low.
- dp_ctrl  input  P_NUM_D_CTRLBITS  control word: [4:2] opcode, [1:0] select s.
- cres  output  1  condition result, combinational from dp_ctrl and current state.
- in_data  input  P_WIDTH  input port data.
- in_valid  input  1  input port data valid.
- in_ready  output  1  input port accept, combinational; high only in the INP accept cycle.
- out_data  output  P_WIDTH  output buffer data, registered.
- out_valid  output  1  output buffer full, registered.
- out_ready  input  1  downstream accept.
- acc  output  P_WIDTH  accumulator A, registered; for observation.

Behaviour:
- Reset (rst==0 at a rising edge): A=0, R0..R3=0, carry C=0, out_valid=0, out_data=0.
  - Reset mid-operation drops any pending output word.
  - in_ready and cres are 0 while rst==0, regardless of dp_ctrl.
- Output drain: if out_valid && out_ready, out_valid clears next edge, unless an OUT loads in the same cycle (see OUT).
- Opcodes. Register writes take effect at the next edge. cres=0 unless stated.
  - 000 NOP: no state change.
  - 001 LD: A <= R[s].
  - 010 ST: R[s] <= A.
  - 011 ADD: {C,A} <= A + R[s], P_WIDTH+1-bit sum; C = carry out.
  - 100 SUB: A <= A - R[s], modulo 2^P_WIDTH; C <= (A < R[s]) unsigned borrow.
  - 101 INP:
    - If in_valid: in_ready=1, A <= in_data, cres=0.
    - Else: in_ready=0, cres=1 (retry). A unchanged.
  - 110 OUT: the buffer is free if !out_valid || out_ready.
    - If free: out_data <= A, out_valid <= 1, cres=0.
    - Else: cres=1 (retry), buffer unchanged.
    - A simultaneous drain and load leaves out_valid=1 with the new data.
  - 111 TST, no state change:
    - s=00: cres = (A==0).
    - s=01: cres = C.
    - s=10: cres = A[P_WIDTH-1].
    - s=11: cres = 1.
- Carry C changes only on ADD and SUB.
- in_ready=0 for every opcode except an accepting INP.
- dp_ctrl is unknown immediately after sequencer reset. This block must not assume any particular opcode in the first cycle after reset deassertion beyond the rules above.
- Latency:
  - Results are visible on acc, out_data and out_valid one edge after the issuing cycle.
  - cres and in_ready are same-cycle combinational.
- No combinational path from out_ready to cres except through the OUT free test. No path from cres back to dp_ctrl inside this block.

Optional Feature:
- Macro: PSEUDO_DP_SATURATE_EN.
- Defined:
  - ADD with carry out loads A = all ones.
  - SUB with borrow loads A = 0.
  - C is still set exactly as in wrapping mode.
- Undefined: ADD/SUB wrap modulo 2^P_WIDTH as specified above.
- All other opcodes are identical in both builds.

Test Plan:
1. Reset and idle:
   - Stimulus: rst=0 for 2 cycles with dp_ctrl=5'b111_11, then rst=1 with NOP.
   - Required: acc=0, out_valid=0, C=0; cres=0 during reset; cres=1 after release with TST s=11.
2. Load, store and add:
   - Stimulus: INP with in_valid=1 and in_data=8'hF0; ST R2; INP 8'h20; ADD R2.
   - Required: in_ready=1 in both INP cycles; acc=8'h10; C=1; TST s=01 gives cres=1.
   - Under PSEUDO_DP_SATURATE_EN: acc=8'hFF.
3. Subtract and borrow:
   - Stimulus: A=8'h03, R1=8'h05, SUB R1.
   - Required: acc=8'hFE, C=1, TST s=10 gives cres=1.
   - Under the macro: acc=8'h00 and TST s=00 gives cres=1.
4. INP stall:
   - Stimulus: INP held 3 cycles with in_valid=0, then in_valid=1 and in_data=8'h5A.
   - Required: cres=1 and in_ready=0 for 3 cycles; then cres=0, in_ready=1, and acc=8'h5A next edge.
5. OUT back-pressure:
   - Stimulus: OUT with A=8'h11 and out_ready=0; next cycle A=8'h22 and OUT with out_ready=0.
   - Required: cres=1 and out_data stays 8'h11.
   - Stimulus: next cycle out_ready=1 with OUT.
   - Required: cres=0; next edge out_data=8'h22 and out_valid=1.
6. Reset mid-operation:
   - Stimulus: out_valid=1 with out_ready=0; assert rst=0 for one edge.
   - Required: out_valid=0, acc=0, R0..R3=0 on the following cycle.
